// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared definitions for the alu_arbiter slice: datapath word size,
//   opcode width and encodings, and the controller FSM state type.
//   No ports.
package alu_arbiter_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned OP_W      = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu
//   Combinational two's-complement ADD/SUB unit with signed-overflow flag.
//   Results wrap modulo 2^WORD_SIZE; unsupported opcodes yield c=0, overflow=0.
// Ports:
//   a, b      in  [WORD_SIZE-1:0]  signed operands
//   op        in  [OP_W-1:0]       opcode (OP_ADD / OP_SUB)
//   c         out [WORD_SIZE-1:0]  result
//   overflow  out                  signed overflow
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [OP_W-1:0]      op,
    output logic [WORD_SIZE-1:0] c,
    output logic                 overflow
);

    localparam int unsigned MSB = WORD_SIZE - 1;

    always_comb begin
        c        = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                c        = a + b;
                // Same-sign operands producing the opposite sign
                overflow = (a[MSB] == b[MSB]) && (c[MSB] != a[MSB]);
            end
            OP_SUB: begin
                c        = a - b;
                // Differing-sign operands with result sign departing from a
                overflow = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB]);
            end
            default: begin
                c        = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter sharing one alu between two requesters. Operands are
//   registered on accept, the alu result is captured in EXEC, and a tagged
//   response is held in RESP until resp_ready.
//   Optional feature macro: ALU_ARB_OVF_STICKY_EN (adds ovf_sticky/ovf_clr).
// Parameters:
//   FIRST_GRANT  requester winning the first contested arbitration after reset
// Ports:
//   clk, rst                      clock, async active-high reset
//   reqN_valid/reqN_ready         request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_op       request operands and opcode
//   resp_valid/resp_ready         response handshake
//   resp_id, resp_c               owning requester, result
//   resp_ovf, resp_err            signed overflow, unsupported opcode
//   ovf_sticky, ovf_clr           per-requester sticky overflow (macro only)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic [OP_W-1:0]      req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    input  logic [OP_W-1:0]      req1_op,
`ifdef ALU_ARB_OVF_STICKY_EN
    output logic [1:0]           ovf_sticky,
    input  logic [1:0]           ovf_clr,
`endif
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [WORD_SIZE-1:0] resp_c,
    output logic                 resp_ovf,
    output logic                 resp_err
);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_last;
    logic [1:0]             w_grant;
    logic                   w_accept;
    logic                   w_resp_hs;

    logic [WORD_SIZE-1:0]   r_a;
    logic [WORD_SIZE-1:0]   r_b;
    logic [OP_W-1:0]        r_op;
    logic                   r_id;

    logic [WORD_SIZE-1:0]   r_resp_c;
    logic                   r_resp_ovf;
    logic                   r_resp_err;
    logic                   r_resp_id;

    logic [WORD_SIZE-1:0]   w_alu_c;
    logic                   w_alu_ovf;

    // Contested requests go to the requester not granted last; r_last
    // resets to the opposite of FIRST_GRANT so FIRST_GRANT wins first.
    always_comb begin
        w_grant = '0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant = r_last ? 2'b01 : 2'b10;
            end else if (req0_valid) begin
                w_grant = 2'b01;
            end else if (req1_valid) begin
                w_grant = 2'b10;
            end
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    assign w_resp_hs  = (r_state == ST_RESP) && resp_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_EXEC;
            ST_EXEC:                w_next = ST_RESP;
            ST_RESP: if (w_resp_hs) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_a  <= w_grant[1] ? req1_a  : req0_a;
            r_b  <= w_grant[1] ? req1_b  : req0_b;
            r_op <= w_grant[1] ? req1_op : req0_op;
            r_id <= w_grant[1];
        end
    end

    alu u_alu (
        .a        (r_a),
        .b        (r_b),
        .op       (r_op),
        .c        (w_alu_c),
        .overflow (w_alu_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_c   <= '0;
            r_resp_ovf <= 1'b0;
            r_resp_err <= 1'b0;
            r_resp_id  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_resp_id <= r_id;
            if (op_supported(r_op)) begin
                r_resp_c   <= w_alu_c;
                r_resp_ovf <= w_alu_ovf;
                r_resp_err <= 1'b0;
            end else begin
                r_resp_c   <= '0;
                r_resp_ovf <= 1'b0;
                r_resp_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ~FIRST_GRANT;
        end else if (w_resp_hs) begin
            r_last <= r_resp_id;
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_id    = r_resp_id;
    assign resp_c     = r_resp_c;
    assign resp_ovf   = r_resp_ovf;
    assign resp_err   = r_resp_err;

`ifdef ALU_ARB_OVF_STICKY_EN
    logic [1:0] r_sticky;
    logic [1:0] w_sticky_set;

    always_comb begin
        w_sticky_set = '0;
        if (w_resp_hs && r_resp_ovf) begin
            w_sticky_set[r_resp_id] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= (r_sticky & ~ovf_clr) | w_sticky_set;
        end
    end

    assign ovf_sticky = r_sticky;
`endif

endmodule
